// File: rtl/life_pkg.sv
// Shared types and constants for the cellular automaton engine and its row rule.
package life_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_PRIME   = 3'd2,
      ST_CALC    = 3'd3,
      ST_EMIT    = 3'd4,
      ST_ADVANCE = 3'd5
   } state_t;

   localparam logic [2:0] DEAD_DEF  = 3'b000;
   localparam logic [2:0] ALIVE_DEF = 3'b111;

   localparam int NBR_W  = 4;
   localparam int RULE_W = 9;

   function automatic logic [NBR_W-1:0] count3(input logic [2:0] b);
      return NBR_W'(b[0]) + NBR_W'(b[1]) + NBR_W'(b[2]);
   endfunction

endpackage

// File: rtl/life_row_rule.sv
// Combinational next-generation row: each cell counts its eight neighbours across
// the previous, current and next rows and applies the birth/survive masks.
module life_row_rule
   import life_pkg::*;
#(
   parameter int                GRID_W       = 160,
   parameter logic [RULE_W-1:0] BIRTH_MASK   = 9'b000001000,
   parameter logic [RULE_W-1:0] SURVIVE_MASK = 9'b000001100
) (
   input  logic [GRID_W-1:0] prev_row,
   input  logic [GRID_W-1:0] cur_row,
   input  logic [GRID_W-1:0] nxt_row,
   input  logic              wrap_en,
   output logic [GRID_W-1:0] new_row
);

   logic [GRID_W+1:0] ext_p;
   logic [GRID_W+1:0] ext_c;
   logic [GRID_W+1:0] ext_n;

   // One guard column each side: the opposite edge when wrapping, dead otherwise.
   always_comb begin
      ext_p = {wrap_en & prev_row[0], prev_row, wrap_en & prev_row[GRID_W-1]};
      ext_c = {wrap_en & cur_row[0],  cur_row,  wrap_en & cur_row[GRID_W-1]};
      ext_n = {wrap_en & nxt_row[0],  nxt_row,  wrap_en & nxt_row[GRID_W-1]};
   end

   always_comb begin
      logic [NBR_W-1:0] n;
      new_row = '0;
      n       = '0;
      for (int c = 0; c < GRID_W; c++) begin
         n = count3(ext_p[c +: 3]) + count3(ext_n[c +: 3])
           + NBR_W'(ext_c[c]) + NBR_W'(ext_c[c+2]);
         new_row[c] = cur_row[c] ? SURVIVE_MASK[n] : BIRTH_MASK[n];
      end
   end

endmodule

// File: rtl/life_engine.sv
// Cellular automaton engine: owns the cell bitmap, computes one generation row by
// row and streams pixel writes (x, y, colour, plot) to a VGA frame-buffer adapter.
//
// state      | meaning
// CLEAR      | zero the grid, paint every pixel dead in raster order
// IDLE       | accept clear / load / step / run-timer expiry
// PRIME      | fetch last and first rows, latch wrap_en and full_redraw
// CALC       | compute next value of the current row
// EMIT       | one pixel per cycle for the current row
// ADVANCE    | commit the row, shift the row window, next row or finish
module life_engine
   import life_pkg::*;
#(
   parameter int                GRID_W       = 160,
   parameter int                GRID_H       = 120,
   parameter int                XW           = 8,
   parameter int                YW           = 7,
   parameter logic [RULE_W-1:0] BIRTH_MASK   = 9'b000001000,
   parameter logic [RULE_W-1:0] SURVIVE_MASK = 9'b000001100,
   parameter logic [2:0]        ALIVE_COLOUR = ALIVE_DEF,
   parameter logic [2:0]        DEAD_COLOUR  = DEAD_DEF,
   parameter int                PERIOD       = 1000000,
   parameter int                GEN_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [XW-1:0]    load_x,
   input  logic [YW-1:0]    load_y,
   input  logic             load_val,
   input  logic             step,
   input  logic             run,
   input  logic             wrap_en,
   input  logic             full_redraw,
   output logic [XW-1:0]    x,
   output logic [YW-1:0]    y,
   output logic [2:0]       colour,
   output logic             plot,
   output logic             busy,
   output logic             gen_done,
   output logic [GEN_W-1:0] gen_count
);

   localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [CW-1:0] C_LAST = CW'(GRID_W - 1);
   localparam logic [RW-1:0] R_LAST = RW'(GRID_H - 1);
   localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);
   localparam logic [XW:0]   X_LIM  = (XW+1)'(GRID_W);
   localparam logic [YW:0]   Y_LIM  = (YW+1)'(GRID_H);

   state_t state_q, state_d;

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [GRID_W-1:0] prev_q, prev_d;
   logic [GRID_W-1:0] cur_q, cur_d;
   logic [GRID_W-1:0] nxt_q, nxt_d;
   logic [GRID_W-1:0] new_q, new_d;
   logic [GRID_W-1:0] save0_q, save0_d;
   logic              wrap_q, wrap_d;
   logic              full_q, full_d;

   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [2:0]        colour_q, colour_d;
   logic              plot_q, plot_d;
   logic              gen_done_q, gen_done_d;
   logic [GEN_W-1:0]  gen_count_q, gen_count_d;

   logic [GRID_W-1:0] cells [GRID_H];
   logic              clr_all;
   logic              row_we;
   logic [RW-1:0]     row_wr_idx;
   logic [GRID_W-1:0] row_wr_data;

   logic              load_ok;
   logic [CW-1:0]     ld_col;
   logic [RW-1:0]     ld_row;
   logic [GRID_W-1:0] nxt_row;
   logic [GRID_W-1:0] rule_row;

   assign load_ok = ({1'b0, load_x} < X_LIM) && ({1'b0, load_y} < Y_LIM);
   assign ld_col  = load_x[CW-1:0];
   assign ld_row  = load_y[RW-1:0];

   // Row 0 is overwritten before the last row is computed, so the wrap uses the saved copy.
   assign nxt_row = (row_q == R_LAST) ? (wrap_q ? save0_q : '0) : cells[row_q + RW'(1)];

   life_row_rule #(
      .GRID_W       (GRID_W),
      .BIRTH_MASK   (BIRTH_MASK),
      .SURVIVE_MASK (SURVIVE_MASK)
   ) u_rule (
      .prev_row (prev_q),
      .cur_row  (cur_q),
      .nxt_row  (nxt_row),
      .wrap_en  (wrap_q),
      .new_row  (rule_row)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         col_q       <= '0;
         row_q       <= '0;
         tmr_q       <= '0;
         prev_q      <= '0;
         cur_q       <= '0;
         nxt_q       <= '0;
         new_q       <= '0;
         save0_q     <= '0;
         wrap_q      <= 1'b0;
         full_q      <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         colour_q    <= '0;
         plot_q      <= 1'b0;
         gen_done_q  <= 1'b0;
         gen_count_q <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         tmr_q       <= tmr_d;
         prev_q      <= prev_d;
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
         new_q       <= new_d;
         save0_q     <= save0_d;
         wrap_q      <= wrap_d;
         full_q      <= full_d;
         x_q         <= x_d;
         y_q         <= y_d;
         colour_q    <= colour_d;
         plot_q      <= plot_d;
         gen_done_q  <= gen_done_d;
         gen_count_q <= gen_count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (clr_all) begin
         for (int i = 0; i < GRID_H; i++) cells[i] <= '0;
      end else if (row_we) begin
         cells[row_wr_idx] <= row_wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_CLEAR;
      end else begin
         case (state_q)
            ST_CLEAR:   if (col_q == C_LAST && row_q == R_LAST) state_d = ST_IDLE;
            ST_IDLE: begin
               if (load)                             state_d = ST_IDLE;
               else if (step)                        state_d = ST_PRIME;
               else if (run && tmr_q == T_LAST)      state_d = ST_PRIME;
            end
            ST_PRIME:   state_d = ST_CALC;
            ST_CALC:    state_d = ST_EMIT;
            ST_EMIT:    if (col_q == C_LAST) state_d = ST_ADVANCE;
            ST_ADVANCE: state_d = (row_q == R_LAST) ? ST_IDLE : ST_CALC;
            default:    state_d = ST_CLEAR;
         endcase
      end
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      tmr_d       = '0;
      prev_d      = prev_q;
      cur_d       = cur_q;
      nxt_d       = nxt_q;
      new_d       = new_q;
      save0_d     = save0_q;
      wrap_d      = wrap_q;
      full_d      = full_q;
      x_d         = x_q;
      y_d         = y_q;
      colour_d    = colour_q;
      plot_d      = 1'b0;
      gen_done_d  = 1'b0;
      gen_count_d = gen_count_q;
      clr_all     = 1'b0;
      row_we      = 1'b0;
      row_wr_idx  = row_q;
      row_wr_data = new_q;

      if (clear) begin
         col_d = '0;
         row_d = '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_all     = 1'b1;
               gen_count_d = '0;
               plot_d      = 1'b1;
               x_d         = XW'(col_q);
               y_d         = YW'(row_q);
               colour_d    = DEAD_COLOUR;
               if (col_q == C_LAST) begin
                  col_d = '0;
                  row_d = (row_q == R_LAST) ? '0 : row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
            ST_IDLE: begin
               if (run && state_d == ST_IDLE)
                  tmr_d = (tmr_q == T_LAST) ? '0 : tmr_q + TW'(1);
               if (load && load_ok) begin
                  row_we              = 1'b1;
                  row_wr_idx          = ld_row;
                  row_wr_data         = cells[ld_row];
                  row_wr_data[ld_col] = load_val;
                  plot_d              = 1'b1;
                  x_d                 = load_x;
                  y_d                 = load_y;
                  colour_d            = load_val ? ALIVE_COLOUR : DEAD_COLOUR;
               end
            end
            ST_PRIME: begin
               prev_d  = wrap_en ? cells[R_LAST] : '0;
               cur_d   = cells[0];
               save0_d = cells[0];
               row_d   = '0;
               col_d   = '0;
               wrap_d  = wrap_en;
               full_d  = full_redraw;
            end
            ST_CALC: begin
               nxt_d = nxt_row;
               new_d = rule_row;
               col_d = '0;
            end
            ST_EMIT: begin
               plot_d   = full_q | (new_q[col_q] ^ cur_q[col_q]);
               x_d      = XW'(col_q);
               y_d      = YW'(row_q);
               colour_d = new_q[col_q] ? ALIVE_COLOUR : DEAD_COLOUR;
               col_d    = (col_q == C_LAST) ? '0 : col_q + CW'(1);
            end
            ST_ADVANCE: begin
               row_we      = 1'b1;
               row_wr_idx  = row_q;
               row_wr_data = new_q;
               prev_d      = cur_q;
               cur_d       = nxt_q;
               if (row_q == R_LAST) begin
                  gen_done_d  = 1'b1;
                  gen_count_d = gen_count_q + GEN_W'(1);
                  row_d       = '0;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign colour    = colour_q;
   assign plot      = plot_q;
   assign busy      = (state_q != ST_IDLE);
   assign gen_done  = gen_done_q;
   assign gen_count = gen_count_q;

endmodule
